// File: rtl/mem_stage_wait.sv
// mem_stage_wait: ARM memory stage with a fixed-latency data memory that stalls the pipeline per access.
module mem_stage_wait #(
  parameter int N = 32,
  parameter int DEPTH = 64,
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ALU_ResIn,
  input  logic [N-1:0] Value_RmIn,
  input  logic         MEM_R_ENIn,
  input  logic         MEM_W_ENIn,
  input  logic         WB_ENIn,
  input  logic [3:0]   DestIn,
  output logic         WB_ENOut,
  output logic         MEM_R_ENOut,
  output logic [3:0]   DestOut,
  output logic [N-1:0] ALU_ResOut,
  output logic [N-1:0] MEM_EX_ALU_ResOut,
  output logic [N-1:0] DataMemoryOut,
  output logic         ready,
  output logic         addrErr
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] addr_q, data_q, off, idx;
  logic wr_q, req, oor, fire;
  logic [N-1:0] mem [DEPTH];
  assign req = MEM_R_ENIn | MEM_W_ENIn;
  assign off = addr_q - N'(BASE_ADDR);
  assign idx = off >> 2;
  // The range check is the only guard, so DEPTH need not be a power of two
  assign oor = (addr_q < N'(BASE_ADDR)) || (idx >= N'(DEPTH));
  assign fire = (state == BUSY) && (cnt == '0);
  assign WB_ENOut = WB_ENIn;
  assign MEM_R_ENOut = MEM_R_ENIn;
  assign DestOut = DestIn;
  assign ALU_ResOut = ALU_ResIn;
  assign MEM_EX_ALU_ResOut = ALU_ResIn;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (req ? BUSY : IDLE) :
          state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  always_comb
    ready = state == IDLE ? ~req : (state == DONE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      DataMemoryOut <= '0;
      addrErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt <= CW'(WAIT_CYCLES - 1);
        addr_q <= ALU_ResIn;
        data_q <= Value_RmIn;
        wr_q <= MEM_W_ENIn;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (fire) begin
        if (oor) addrErr <= 1'b1;
        if (wr_q && !oor) mem[idx[AW-1:0]] <= data_q;
        if (!wr_q) DataMemoryOut <= oor ? '0 : mem[idx[AW-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_wait.sv
// tb_mem_stage_wait: directed bench with a transaction-level memory model for the default stage and literal checks for a short-latency one.
module tb_mem_stage_wait;
  logic clk, rst;
  logic [31:0] a_addr, a_data;
  logic a_r, a_w, a_wb;
  logic [3:0] a_dest;
  logic a_wbo, a_ro, a_ready, a_err;
  logic [3:0] a_desto;
  logic [31:0] a_reso, a_fwd, a_dout;
  logic [31:0] b_addr, b_data;
  logic b_r, b_w;
  logic b_wbo, b_ro, b_ready, b_err;
  logic [3:0] b_desto;
  logic [31:0] b_reso, b_fwd, b_dout;
  int checks = 0, errors = 0;
  logic chk_en = 0;
  logic exp_ready, exp_err;
  logic [31:0] exp_dout;
  logic [31:0] model_mem [64];
  logic [15:0] rhist = '0;

  mem_stage_wait dut_a (
    .clk(clk), .rst(rst), .ALU_ResIn(a_addr), .Value_RmIn(a_data),
    .MEM_R_ENIn(a_r), .MEM_W_ENIn(a_w), .WB_ENIn(a_wb), .DestIn(a_dest),
    .WB_ENOut(a_wbo), .MEM_R_ENOut(a_ro), .DestOut(a_desto), .ALU_ResOut(a_reso),
    .MEM_EX_ALU_ResOut(a_fwd), .DataMemoryOut(a_dout), .ready(a_ready), .addrErr(a_err)
  );

  mem_stage_wait #(.WAIT_CYCLES(1), .DEPTH(10)) dut_b (
    .clk(clk), .rst(rst), .ALU_ResIn(b_addr), .Value_RmIn(b_data),
    .MEM_R_ENIn(b_r), .MEM_W_ENIn(b_w), .WB_ENIn(1'b0), .DestIn(4'd0),
    .WB_ENOut(b_wbo), .MEM_R_ENOut(b_ro), .DestOut(b_desto), .ALU_ResOut(b_reso),
    .MEM_EX_ALU_ResOut(b_fwd), .DataMemoryOut(b_dout), .ready(b_ready), .addrErr(b_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ready", a_ready, exp_ready);
    chk("dout", a_dout, exp_dout);
    chk("addrErr", a_err, exp_err);
    chk("DestOut", a_desto, a_dest);
    chk("ALU_ResOut", a_reso, a_addr);
    chk("fwd", a_fwd, a_addr);
    chk("WB_ENOut", a_wbo, a_wb);
    chk("MEM_R_ENOut", a_ro, a_r);
    rhist = {rhist[14:0], a_ready};
  end

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    exp_dout = '0;
    exp_err = 0;
  endtask

  task automatic idle(input int n);
    a_r = 0; a_w = 0; exp_ready = 1;
    repeat (n) step();
  endtask

  // One access in the default stage: 4 stall cycles then a DONE cycle
  task automatic access(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic bad;
    int ia;
    a_r = r; a_w = w; a_addr = addr; a_data = data;
    exp_ready = 0;
    repeat (4) step();
    bad = (addr < 1024) || ((addr - 1024) / 4 >= 64);
    ia = bad ? 0 : int'((addr - 1024) / 4);
    if (bad) exp_err = 1;
    if (w) begin
      if (!bad) model_mem[ia] = data;
    end else begin
      exp_dout = bad ? '0 : model_mem[ia];
    end
    exp_ready = 1;
    step();
  endtask

  task automatic b_acc(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] dexp, input logic eexp);
    b_r = r; b_w = w; b_addr = addr; b_data = data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_ready", b_ready, i == 2);
      if (i == 2) begin
        chk("b_dout", b_dout, dexp);
        chk("b_addrErr", b_err, eexp);
      end
      @(posedge clk);
      #1;
    end
    b_r = 0; b_w = 0;
  endtask

  initial begin
    rst = 0;
    a_r = 0; a_w = 0; a_wb = 1; a_dest = 4'd5; a_addr = 32'h1234; a_data = 0;
    b_r = 0; b_w = 0; b_addr = 0; b_data = 0;
    clear_model();
    exp_ready = 1;
    chk_en = 1;
    step();
    rst = 1;
    idle(3);
    chk("lit_dest", a_desto, 32'd5);
    chk("lit_res", a_reso, 32'h1234);
    chk("lit_dout_reset", a_dout, 32'h0);
    access(0, 1, 32'd1032, 32'hDEADBEEF);
    chk("lit_store_ready_seq", rhist[4:0], 32'b00001);
    access(1, 0, 32'd1032, 32'h0);
    chk("lit_load_data", a_dout, 32'hDEADBEEF);
    chk("lit_load_ready_seq", rhist[4:0], 32'b00001);
    idle(1);
    access(1, 0, 32'd1000, 32'h0);
    chk("lit_oob_load_data", a_dout, 32'h0);
    chk("lit_oob_err", a_err, 32'd1);
    chk("lit_oob_ready_seq", rhist[4:0], 32'b00001);
    access(0, 1, 32'd1280, 32'h12345678);
    idle(1);
    access(1, 0, 32'd1032, 32'h0);
    idle(1);
    a_r = 0; a_w = 1; a_addr = 32'd1028; a_data = 32'h11112222;
    exp_ready = 0;
    step();
    step();
    rst = 0;
    a_w = 0;
    clear_model();
    exp_ready = 1;
    step();
    rst = 1;
    chk("lit_rst_dout", a_dout, 32'h0);
    chk("lit_rst_err", a_err, 32'h0);
    idle(1);
    access(1, 0, 32'd1028, 32'h0);
    chk("lit_after_rst_ready_seq", rhist[4:0], 32'b00001);
    chk("lit_after_rst_mem1", a_dout, 32'h0);
    idle(1);
    b_acc(0, 1, 32'd1056, 32'h00000055, 32'h0, 0);
    b_acc(1, 0, 32'd1056, 32'h0, 32'h00000055, 0);
    b_acc(1, 1, 32'd1060, 32'hA5A5A5A5, 32'h00000055, 0);
    b_acc(1, 0, 32'd1060, 32'h0, 32'hA5A5A5A5, 0);
    b_acc(1, 0, 32'd1064, 32'h0, 32'h0, 1);
    idle(2);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
